ram_access_sequencer: RTL and testbench

Shares the single 16-bit external RAM between the fetch stage and the memory stage. Each 32-bit access is split into two sequenced half-word RAM cycles: high half first, then low half. The block arbitrates between the two requesters and answers each with a one-cycle ready pulse. It replaces the single-cycle, unsequenced RAM path between the pipeline and the RAM.

---
 rtl/ram_access_sequencer_pkg.sv | 19 +
 rtl/ram_access_sequencer_if.sv | 37 +++
 rtl/ram_access_sequencer_rr_arbiter.sv | 22 ++
 rtl/ram_access_sequencer.sv | 151 +++++++++++++++
 tb/tb_ram_access_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ram_access_sequencer_pkg.sv
// Shared types for the RAM sequencer: FSM states, requester ids and data widths.
package mem_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        MEM   = 1'b1
    } grant_e;

endpackage

// File: rtl/ram_access_sequencer_if.sv
// Pipeline-side request/response signals plus the 16-bit RAM pins of the sequencer.
interface ram_access_sequencer_if #(
    parameter int ADDR_W = 18
);
    import mem_ctrl_pkg::*;

    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic [WORD_W-1:0]   if_rdata;
    logic                if_ready;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   mem_rdata;
    logic                mem_ready;

    logic [ADDR_W-1:0]   ram_addr;
    logic [HALF_W-1:0]   ram_wdata;
    logic [HALF_W-1:0]   ram_rdata;
    logic                ram_en;
    logic                ram_we;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
               ram_addr, ram_wdata, ram_en, ram_we
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
               ram_addr, ram_wdata, ram_en, ram_we
    );

endinterface

// File: rtl/ram_access_sequencer_rr_arbiter.sv
// Combinational two-way arbiter: a lone request wins, a tie goes to whoever was not granted last.
module ram_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
    input  grant_e last_grant,
    output logic   grant_valid,
    output grant_e grant_id
);

    always_comb begin
        grant_valid = if_req | mem_req;
        grant_id    = FETCH;
        if (if_req && mem_req) begin
            grant_id = (last_grant == FETCH) ? MEM : FETCH;
        end else if (mem_req) begin
            grant_id = MEM;
        end
    end

endmodule

// File: rtl/ram_access_sequencer.sv
// Splits each 32-bit fetch/memory access into two 16-bit RAM cycles (high half, then low half).
// Ready pulses 2*(RAM_WAIT+1)+1 cycles after the grant; requests are only sampled in IDLE.
module ram_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int RAM_WAIT = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_access_sequencer_if.slave bus
);

    localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT);

    state_e              state_q;
    logic [2:0]          wait_cnt_q;
    grant_e              last_grant_q;
    grant_e              grant_q;
    logic [ADDR_W-1:0]   base_q;
    logic                we_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [HALF_W-1:0]   buf_hi_q;

    logic                ram_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [HALF_W-1:0]   ram_wdata_q;
    logic                if_ready_q;
    logic                mem_ready_q;
    logic [WORD_W-1:0]   if_rdata_q;
    logic [WORD_W-1:0]   mem_rdata_q;

    logic                grant_valid;
    grant_e              grant_id;
    logic [ADDR_W-1:0]   req_addr_d;
    logic [ADDR_W-1:0]   base_d;
    logic                we_d;
    logic [WORD_W-1:0]   wdata_d;
    logic                phase_end;

    ram_rr_arbiter u_arb (
        .if_req      (bus.if_req),
        .mem_req     (bus.mem_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Byte address -> even half-word address: drop the byte offset within the word.
    always_comb begin
        req_addr_d = bus.if_addr;
        we_d       = 1'b0;
        wdata_d    = '0;
        if (grant_id == MEM) begin
            req_addr_d = bus.mem_addr;
            we_d       = bus.mem_we;
            wdata_d    = bus.mem_wdata;
        end
        base_d = (req_addr_d & ~ADDR_W'(3)) >> 1;
    end

    assign phase_end = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            last_grant_q <= FETCH;
            grant_q      <= FETCH;
            base_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            buf_hi_q     <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        grant_q      <= grant_id;
                        last_grant_q <= grant_id;
                        base_q       <= base_d;
                        we_q         <= we_d;
                        wdata_q      <= wdata_d;
                        wait_cnt_q   <= '0;
                        ram_en_q     <= 1'b1;
                        ram_we_q     <= we_d;
                        ram_addr_q   <= base_d;
                        ram_wdata_q  <= wdata_d[WORD_W-1:HALF_W];
                        state_q      <= HI;
                    end
                end
                HI: begin
                    if (phase_end) begin
                        if (!we_q) begin
                            buf_hi_q <= bus.ram_rdata;
                        end
                        wait_cnt_q  <= '0;
                        ram_addr_q  <= {base_q[ADDR_W-1:1], 1'b1};
                        ram_wdata_q <= wdata_q[HALF_W-1:0];
                        state_q     <= LO;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                LO: begin
                    if (phase_end) begin
                        wait_cnt_q <= '0;
                        ram_en_q   <= 1'b0;
                        ram_we_q   <= 1'b0;
                        state_q    <= DONE;
                        // Low half goes straight from the RAM pins into the result word.
                        if (grant_q == MEM) begin
                            mem_ready_q <= 1'b1;
                            if (!we_q) begin
                                mem_rdata_q <= {buf_hi_q, bus.ram_rdata};
                            end
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= {buf_hi_q, bus.ram_rdata};
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed bench: one sequencer with RAM_WAIT=0 and one with RAM_WAIT=2, each on a small RAM model.
module tb_ram_access_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ram_access_sequencer_if #(.ADDR_W(18)) b0 ();
    ram_access_sequencer_if #(.ADDR_W(18)) b2 ();

    ram_access_sequencer #(.ADDR_W(18), .RAM_WAIT(0)) u0 (
        .clock (clk),
        .reset (reset),
        .bus   (b0)
    );

    ram_access_sequencer #(.ADDR_W(18), .RAM_WAIT(2)) u2 (
        .clock (clk),
        .reset (reset),
        .bus   (b2)
    );

    logic [15:0] ram0 [0:255];
    logic [15:0] ram2 [0:255];

    assign b0.ram_rdata = ram0[b0.ram_addr[7:0]];
    assign b2.ram_rdata = ram2[b2.ram_addr[7:0]];

    // Preload happens while reset is held; afterwards the RAMs only see DUT writes.
    always @(posedge clk) begin
        if (reset) begin
            ram0[8'h08] <= 16'hDEAD;
            ram0[8'h09] <= 16'hBEEF;
            ram0[8'h04] <= 16'hCAFE;
            ram0[8'h05] <= 16'hF00D;
            ram2[8'h08] <= 16'h1357;
            ram2[8'h09] <= 16'h2468;
        end else begin
            if (b0.ram_en && b0.ram_we) ram0[b0.ram_addr[7:0]] <= b0.ram_wdata;
            if (b2.ram_en && b2.ram_we) ram2[b2.ram_addr[7:0]] <= b2.ram_wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        bit exp_mem;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        b0.if_req = 1'b0; b0.if_addr = '0; b0.mem_req = 1'b0; b0.mem_we = 1'b0;
        b0.mem_addr = '0; b0.mem_wdata = '0;
        b2.if_req = 1'b0; b2.if_addr = '0; b2.mem_req = 1'b0; b2.mem_we = 1'b0;
        b2.mem_addr = '0; b2.mem_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_ram_en",    b0.ram_en,    0);
        chk("rst_ram_we",    b0.ram_we,    0);
        chk("rst_ram_addr",  b0.ram_addr,  0);
        chk("rst_ram_wdata", b0.ram_wdata, 0);
        chk("rst_if_ready",  b0.if_ready,  0);
        chk("rst_mem_ready", b0.mem_ready, 0);
        chk("rst_if_rdata",  b0.if_rdata,  0);
        chk("rst_mem_rdata", b0.mem_rdata, 0);
        chk("rst_w2_en",     b2.ram_en,    0);

        // Fetch read of 0x10: RAM half-words 8 then 9; req dropped after the grant.
        reset = 1'b0;
        b0.if_req = 1'b1; b0.if_addr = 18'h00010;
        @(negedge clk);
        chk("f_hi_addr", b0.ram_addr, 32'h8);
        chk("f_hi_en",   b0.ram_en,   1);
        chk("f_hi_we",   b0.ram_we,   0);
        chk("f_hi_rdy",  b0.if_ready, 0);
        b0.if_req = 1'b0;
        @(negedge clk);
        chk("f_lo_addr", b0.ram_addr, 32'h9);
        @(negedge clk);
        chk("f_ready",   b0.if_ready, 1);
        chk("f_rdata",   b0.if_rdata, 32'hDEADBEEF);
        chk("f_done_en", b0.ram_en,   0);
        @(negedge clk);
        chk("f_ready_fall", b0.if_ready, 0);

        // Memory write of 0x12345678 to 0x24.
        b0.mem_req = 1'b1; b0.mem_we = 1'b1; b0.mem_addr = 18'h00024; b0.mem_wdata = 32'h12345678;
        @(negedge clk);
        chk("w_hi_addr", b0.ram_addr,  32'h12);
        chk("w_hi_we",   b0.ram_we,    1);
        chk("w_hi_dat",  b0.ram_wdata, 32'h1234);
        b0.mem_req = 1'b0;
        @(negedge clk);
        chk("w_lo_addr", b0.ram_addr,  32'h13);
        chk("w_lo_we",   b0.ram_we,    1);
        chk("w_lo_dat",  b0.ram_wdata, 32'h5678);
        @(negedge clk);
        chk("w_ready",      b0.mem_ready, 1);
        chk("w_done_we",    b0.ram_we,    0);
        chk("w_rdata_keep", b0.mem_rdata, 0);
        chk("w_ram_hi",     ram0[8'h12],  32'h1234);
        chk("w_ram_lo",     ram0[8'h13],  32'h5678);
        @(negedge clk);

        // Unaligned read of 0x27 reads back the word at 0x24.
        b0.mem_req = 1'b1; b0.mem_we = 1'b0; b0.mem_addr = 18'h00027;
        @(negedge clk);
        chk("u_hi_addr", b0.ram_addr, 32'h12);
        chk("u_hi_we",   b0.ram_we,   0);
        b0.mem_req = 1'b0;
        @(negedge clk);
        chk("u_lo_addr", b0.ram_addr, 32'h13);
        @(negedge clk);
        chk("u_ready", b0.mem_ready, 1);
        chk("u_rdata", b0.mem_rdata, 32'h12345678);
        @(negedge clk);

        // Intervening fetch must leave mem_rdata alone.
        b0.if_req = 1'b1; b0.if_addr = 18'h00008;
        @(negedge clk);
        b0.if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("f2_rdata",    b0.if_rdata,  32'hCAFEF00D);
        chk("f2_mem_keep", b0.mem_rdata, 32'h12345678);
        chk("f2_mem_rdy",  b0.mem_ready, 0);
        @(negedge clk);

        // Reset during the LO phase of a write aborts it immediately.
        b0.mem_req = 1'b1; b0.mem_we = 1'b1; b0.mem_addr = 18'h00030; b0.mem_wdata = 32'hAAAA5555;
        @(negedge clk);
        b0.mem_req = 1'b0;
        @(negedge clk);
        chk("r_lo_we", b0.ram_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("r_async_we", b0.ram_we, 0);
        chk("r_async_en", b0.ram_en, 0);
        b0.if_req = 1'b1; b0.if_addr = 18'h00010;
        b0.mem_req = 1'b1; b0.mem_we = 1'b0; b0.mem_addr = 18'h00024;
        @(negedge clk);
        chk("r_no_mem_rdy", b0.mem_ready, 0);
        chk("r_no_if_rdy",  b0.if_ready,  0);
        reset = 1'b0;

        // Both requests held: MEM, FETCH, MEM, one ready every 4 cycles.
        for (int k = 0; k < 3; k++) begin
            exp_mem = (k % 2 == 0);
            @(negedge clk);
            chk("alt_hi_addr", b0.ram_addr, exp_mem ? 32'h12 : 32'h8);
            @(negedge clk);
            @(negedge clk);
            chk("alt_mem_rdy", b0.mem_ready, exp_mem ? 32'd1 : 32'd0);
            chk("alt_if_rdy",  b0.if_ready,  exp_mem ? 32'd0 : 32'd1);
            chk("alt_rdata", exp_mem ? b0.mem_rdata : b0.if_rdata,
                exp_mem ? 32'h12345678 : 32'hDEADBEEF);
            @(negedge clk);
            chk("alt_idle_rdy", {b0.mem_ready, b0.if_ready}, 0);
        end
        b0.if_req = 1'b0; b0.mem_req = 1'b0;

        // RAM_WAIT=2: each half-word address held 3 cycles, ready 7 cycles after grant.
        b2.if_req = 1'b1; b2.if_addr = 18'h00010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) b2.if_req = 1'b0;
            chk("w2_addr", b2.ram_addr, (i < 3) ? 32'h8 : 32'h9);
            chk("w2_en",   b2.ram_en,   1);
            chk("w2_rdy",  b2.if_ready, 0);
        end
        @(negedge clk);
        chk("w2_ready", b2.if_ready, 1);
        chk("w2_rdata", b2.if_rdata, 32'h13572468);
        @(negedge clk);
        chk("w2_ready_fall", b2.if_ready, 0);
        chk("w0_quiet",      b0.ram_en,   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
